store_load_buffer: RTL and testbench

- Sits between the core's load/store path and the byte-addressed 64-bit data memory.
- The memory has a combinational read when mem_read is high, and writes a full 8 bytes at the posedge when mem_write is high.
- The block queues stores in a small FIFO and drains them to memory. Sub-doubleword stores are done by read-modify-write on the aligned doubleword.
- Loads are served only after all queued stores have drained. The loaded value is extracted and sign/zero-extended before return.

---
 rtl/sb_pkg.sv | 76 +++++++
 rtl/sb_fifo.sv | 57 +++++
 rtl/store_load_buffer.sv | 157 +++++++++++++++
 tb/tb_store_load_buffer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// Shared types and helpers for the store/load buffer: access-size encoding,
// controller states, the queued-store record and the byte-lane helpers.
package sb_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RMW_RD = 3'd1,
        ST_WR     = 3'd2,
        ST_LD     = 3'd3,
        ST_RSP    = 3'd4
    } state_e;

    // One queued store: byte address, right-justified data and access size.
    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] data;
        size_e       size;
    } st_entry_t;

    // Natural alignment: the low address bits covered by the size must be zero.
    function automatic logic align_ok(input logic [2:0] off, input size_e size);
        logic ok;
        case (size)
            SZ_B:    ok = 1'b1;
            SZ_H:    ok = (off[0] == 1'b0);
            SZ_W:    ok = (off[1:0] == 2'b00);
            default: ok = (off == 3'b000);
        endcase
        return ok;
    endfunction

    // Replace the (1 << size) bytes starting at byte lane 'off' of 'old'
    // with the low bytes of 'data'.
    function automatic logic [63:0] merge_bytes(input logic [63:0] old,
                                                input logic [63:0] data,
                                                input logic [2:0]  off,
                                                input size_e       size);
        logic [63:0] r;
        int          n;
        int          o;
        r = old;
        n = 1 << int'(size);
        o = int'(off);
        for (int b = 0; b < 8; b++) begin
            if ((b >= o) && (b < o + n)) begin
                r[b*8 +: 8] = data[(b-o)*8 +: 8];
            end
        end
        return r;
    endfunction

    // Pull the addressed bytes out of a doubleword and sign- or zero-extend.
    function automatic logic [63:0] extract_ext(input logic [63:0] dword,
                                                input logic [2:0]  off,
                                                input size_e       size,
                                                input logic        is_unsigned);
        logic [63:0] s;
        logic [63:0] r;
        s = dword >> {off, 3'b000};
        case (size)
            SZ_B:    r = is_unsigned ? {56'd0, s[7:0]}  : {{56{s[7]}},  s[7:0]};
            SZ_H:    r = is_unsigned ? {48'd0, s[15:0]} : {{48{s[15]}}, s[15:0]};
            SZ_W:    r = is_unsigned ? {32'd0, s[31:0]} : {{32{s[31]}}, s[31:0]};
            default: r = s;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sb_fifo.sv
// Store queue: DEPTH-entry synchronous FIFO with wrap-around pointers.
// Push is refused when full and pop when empty; both may happen together.
module sb_fifo
    import sb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  st_entry_t                i_entry,
    input  logic                     i_pop,
    output st_entry_t                o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    st_entry_t       r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;
    logic            w_push;
    logic            w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Pointer and occupancy bookkeeping; reset empties the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are meaningless until pushed, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_entry;
    end

endmodule

// File: rtl/store_load_buffer.sv
// Store/load buffer between the core and a 64-bit byte-addressed memory.
// Stores queue in sb_fifo and drain one at a time (sub-doubleword stores by
// read-modify-write); loads are taken only when the queue is empty and idle.
module store_load_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [63:0] st_addr,
    input  logic [63:0] st_data,
    input  logic [1:0]  st_size,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [63:0] ld_addr,
    input  logic [1:0]  ld_size,
    input  logic        ld_unsigned,
    output logic        ld_rvalid,
    output logic [63:0] ld_rdata,
    output logic        err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    state_e                 r_state;
    logic [63:0]            r_merge;
    logic [63:0]            r_ld_addr;
    size_e                  r_ld_size;
    logic                   r_ld_uns;
    logic [63:0]            r_ld_rdata;
    logic                   r_rvalid;
    logic                   r_err;

    st_entry_t              w_head;
    st_entry_t              w_entry;
    logic                   w_full;
    logic                   w_empty;
    logic [$clog2(DEPTH):0] w_count;
    logic                   w_st_acc;
    logic                   w_st_ok;
    logic                   w_ld_acc;
    logic                   w_ld_ok;
    logic                   w_push;
    logic                   w_pop;

    assign st_ready = !w_full;
    assign ld_ready = (w_count == '0) && (r_state == ST_IDLE);

    assign w_st_acc = st_valid && st_ready;
    assign w_st_ok  = align_ok(st_addr[2:0], size_e'(st_size));
    assign w_ld_acc = ld_valid && ld_ready;
    assign w_ld_ok  = align_ok(ld_addr[2:0], size_e'(ld_size));
    assign w_push   = w_st_acc && w_st_ok;
    assign w_pop    = (r_state == ST_WR);

    assign w_entry.addr = st_addr;
    assign w_entry.data = st_data;
    assign w_entry.size = size_e'(st_size);

    assign ld_rvalid = r_rvalid;
    assign ld_rdata  = r_ld_rdata;
    assign err       = r_err;

    sb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_entry (w_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Controller: loads win over draining; each drain ends with a pop in WR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_merge    <= '0;
            r_ld_addr  <= '0;
            r_ld_size  <= SZ_B;
            r_ld_uns   <= 1'b0;
            r_ld_rdata <= '0;
            r_rvalid   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err    <= (w_st_acc && !w_st_ok) || (w_ld_acc && !w_ld_ok);
            r_rvalid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_ld_acc && w_ld_ok) begin
                        r_ld_addr <= ld_addr;
                        r_ld_size <= size_e'(ld_size);
                        r_ld_uns  <= ld_unsigned;
                        r_state   <= ST_LD;
                    end else if (!w_empty) begin
                        r_state <= (w_head.size == SZ_D) ? ST_WR : ST_RMW_RD;
                    end
                end
                ST_RMW_RD: begin
                    r_merge <= mem_rdata;
                    r_state <= ST_WR;
                end
                ST_WR: begin
                    r_state <= ST_IDLE;
                end
                ST_LD: begin
                    r_ld_rdata <= extract_ext(mem_rdata, r_ld_addr[2:0], r_ld_size, r_ld_uns);
                    r_rvalid   <= 1'b1;
                    r_state    <= ST_RSP;
                end
                ST_RSP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory port decoded purely from registered state, queue head and merge data.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            ST_RMW_RD: begin
                mem_read = 1'b1;
                mem_addr = {w_head.addr[63:3], 3'b000};
            end
            ST_WR: begin
                mem_write = 1'b1;
                mem_addr  = {w_head.addr[63:3], 3'b000};
                mem_wdata = (w_head.size == SZ_D) ? w_head.data
                          : merge_bytes(r_merge, w_head.data, w_head.addr[2:0], w_head.size);
            end
            ST_LD: begin
                mem_read = 1'b1;
                mem_addr = {r_ld_addr[63:3], 3'b000};
            end
            default: begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_store_load_buffer.sv
// Scoreboard bench for store_load_buffer: directed stimulus pushes expected
// memory reads, writes, load responses and error pulses into queues; a
// negedge monitor pops and compares them as the DUT produces them.
module tb_store_load_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [63:0] st_addr = '0;
    logic [63:0] st_data = '0;
    logic [1:0]  st_size = '0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [63:0] ld_addr = '0;
    logic [1:0]  ld_size = '0;
    logic        ld_unsigned = 1'b0;
    logic        ld_rvalid;
    logic [63:0] ld_rdata;
    logic        err;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    always #5 clk = ~clk;

    store_load_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_data(st_data), .st_size(st_size),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .ld_size(ld_size), .ld_unsigned(ld_unsigned),
        .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .err(err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Memory model: 256 bytes, byte i initialised to i, combinational read.
    logic [7:0] mem [0:255];

    always_comb begin
        mem_rdata = '0;
        if (mem_read) begin
            for (int b = 0; b < 8; b++) mem_rdata[b*8 +: 8] = mem[(int'(mem_addr[7:0]) + b) & 255];
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        forever begin
            @(posedge clk);
            if (mem_write) begin
                for (int b = 0; b < 8; b++) mem[(int'(mem_addr[7:0]) + b) & 255] = mem_wdata[b*8 +: 8];
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [63:0] addr; logic [63:0] data; } wr_t;
    typedef struct { logic [63:0] data; int acc; } ld_t;

    wr_t         exp_wr [$];
    logic [63:0] exp_rd [$];
    ld_t         exp_ld [$];
    int          exp_err [$];

    int n_chk  = 0;
    int n_pass = 0;
    bit saw_full = 1'b0;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic checkint(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic fail_event(input string name);
        n_chk++;
        $display("FAIL %s: event occurred with nothing expected (t=%0t)", name, $time);
    endtask

    // Monitor: every DUT memory access, load response and error pulse must be expected.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_write) begin
                if (exp_wr.size() == 0) fail_event("unexpected_write");
                else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    check64("wr_addr", mem_addr, w.addr);
                    check64("wr_data", mem_wdata, w.data);
                end
            end
            if (mem_read) begin
                if (exp_rd.size() == 0) fail_event("unexpected_read");
                else begin
                    logic [63:0] a;
                    a = exp_rd.pop_front();
                    check64("rd_addr", mem_addr, a);
                end
            end
            if (ld_rvalid) begin
                if (exp_ld.size() == 0) fail_event("unexpected_rvalid");
                else begin
                    ld_t l;
                    l = exp_ld.pop_front();
                    check64("ld_rdata", ld_rdata, l.data);
                    checkint("ld_latency", cyc, l.acc + 1);
                end
            end
            if (err) begin
                if (exp_err.size() == 0) fail_event("unexpected_err");
                else begin
                    int e;
                    e = exp_err.pop_front();
                    checkint("err_latency", cyc, e);
                end
            end
        end
    end

    task automatic expect_st(input logic [63:0] dw, input logic [63:0] wdata, input bit rmw);
        if (rmw) exp_rd.push_back(dw);
        exp_wr.push_back('{dw, wdata});
    endtask

    task automatic do_store(input logic [63:0] a, input logic [63:0] d, input logic [1:0] sz,
                            input bit misaligned);
        int n;
        n = 0;
        st_valid = 1'b1; st_addr = a; st_data = d; st_size = sz;
        while (!st_ready && n < 100) begin
            saw_full = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) fail_event("st_ready_timeout");
        @(posedge clk); #1;
        st_valid = 1'b0;
        if (misaligned) exp_err.push_back(cyc);
    endtask

    task automatic do_load(input logic [63:0] a, input logic [1:0] sz, input logic uns,
                           input bit misaligned, input logic [63:0] exp_data);
        int n;
        n = 0;
        ld_valid = 1'b1; ld_addr = a; ld_size = sz; ld_unsigned = uns;
        while (!ld_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) fail_event("ld_ready_timeout");
        checkint("ld_ready_after_drain", exp_wr.size(), 0);
        if (!misaligned) exp_rd.push_back({a[63:3], 3'b000});
        @(posedge clk); #1;
        ld_valid = 1'b0;
        if (misaligned) exp_err.push_back(cyc);
        else exp_ld.push_back('{exp_data, cyc});
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset state
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check64("rst_mem_read", mem_read, 0);
        check64("rst_mem_write", mem_write, 0);
        check64("rst_mem_addr", mem_addr, 0);
        check64("rst_mem_wdata", mem_wdata, 0);
        check64("rst_ld_rvalid", ld_rvalid, 0);
        check64("rst_ld_rdata", ld_rdata, 0);
        check64("rst_err", err, 0);
        check64("rst_st_ready", st_ready, 1);
        check64("rst_ld_ready", ld_ready, 1);
        @(posedge clk); #1;

        // Doubleword store then load back
        expect_st(64'h8, 64'h1122334455667788, 1'b0);
        do_store(64'h8, 64'h1122334455667788, 2'd3, 1'b0);
        do_load(64'h8, 2'd3, 1'b0, 1'b0, 64'h1122334455667788);
        idle(3);

        // Byte store by read-modify-write into initialised memory
        expect_st(64'h0, 64'h07060504AB020100, 1'b1);
        do_store(64'h3, 64'hAB, 2'd0, 1'b0);

        // Byte store then signed/unsigned extraction
        expect_st(64'h10, 64'h17161514131211F0, 1'b1);
        do_store(64'h10, 64'hF0, 2'd0, 1'b0);
        do_load(64'h10, 2'd0, 1'b0, 1'b0, 64'hFFFFFFFFFFFFFFF0);
        do_load(64'h10, 2'd0, 1'b1, 1'b0, 64'h00000000000000F0);
        do_load(64'h10, 2'd1, 1'b0, 1'b0, 64'h00000000000011F0);
        do_load(64'h10, 2'd2, 1'b1, 1'b0, 64'h00000000131211F0);

        // Negative halfword and word at upper lanes
        expect_st(64'h18, 64'h1F1E92341B1A1918, 1'b1);
        do_store(64'h1C, 64'h9234, 2'd1, 1'b0);
        do_load(64'h1C, 2'd1, 1'b0, 1'b0, 64'hFFFFFFFFFFFF9234);
        do_load(64'h1C, 2'd1, 1'b1, 1'b0, 64'h0000000000009234);
        expect_st(64'h48, 64'h800000014B4A4948, 1'b1);
        do_store(64'h4C, 64'h80000001, 2'd2, 1'b0);
        do_load(64'h4C, 2'd2, 1'b0, 1'b0, 64'hFFFFFFFF80000001);
        do_load(64'h4C, 2'd2, 1'b1, 1'b0, 64'h0000000080000001);
        idle(3);

        // Six back-to-back halfword stores fill the queue
        expect_st(64'h20, 64'h272625242322A1B1, 1'b1);
        expect_st(64'h20, 64'h27262524C3D3A1B1, 1'b1);
        expect_st(64'h20, 64'h2726E5F5C3D3A1B1, 1'b1);
        expect_st(64'h20, 64'h0717E5F5C3D3A1B1, 1'b1);
        expect_st(64'h28, 64'h2F2E2D2C2B2A1929, 1'b1);
        expect_st(64'h28, 64'h2F2E2D2C3B4B1929, 1'b1);
        do_store(64'h20, 64'hA1B1, 2'd1, 1'b0);
        do_store(64'h22, 64'hC3D3, 2'd1, 1'b0);
        do_store(64'h24, 64'hE5F5, 2'd1, 1'b0);
        do_store(64'h26, 64'h0717, 2'd1, 1'b0);
        do_store(64'h28, 64'h1929, 2'd1, 1'b0);
        do_store(64'h2A, 64'h3B4B, 2'd1, 1'b0);
        check64("burst_ld_ready_low", ld_ready, 0);
        do_load(64'h20, 2'd3, 1'b0, 1'b0, 64'h0717E5F5C3D3A1B1);
        do_load(64'h2A, 2'd1, 1'b1, 1'b0, 64'h0000000000003B4B);
        idle(3);

        // Misaligned requests are dropped with an error pulse
        do_store(64'h2, 64'hDEAD, 2'd2, 1'b1);
        do_store(64'h4, 64'hBEEF, 2'd3, 1'b1);
        do_load(64'h1, 2'd1, 1'b0, 1'b1, 64'h0);
        do_load(64'hC, 2'd3, 1'b0, 1'b1, 64'h0);
        idle(3);
        check64("misalign_ld_ready", ld_ready, 1);

        // Store and load accepted together: load served first
        exp_rd.push_back(64'h38);
        exp_wr.push_back('{64'h30, 64'hDEADBEEF00C0FFEE});
        st_valid = 1'b1; st_addr = 64'h30; st_data = 64'hDEADBEEF00C0FFEE; st_size = 2'd3;
        ld_valid = 1'b1; ld_addr = 64'h38; ld_size = 2'd3; ld_unsigned = 1'b0;
        check64("dual_st_ready", st_ready, 1);
        check64("dual_ld_ready", ld_ready, 1);
        @(posedge clk); #1;
        st_valid = 1'b0; ld_valid = 1'b0;
        exp_ld.push_back('{64'h3F3E3D3C3B3A3938, cyc});
        do_load(64'h30, 2'd3, 1'b0, 1'b0, 64'hDEADBEEF00C0FFEE);
        idle(3);

        // Reset in the middle of a read-modify-write discards the store
        do_store(64'h40, 64'h55, 2'd0, 1'b0);
        n = 0;
        while (!mem_read && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checkint("rmw_reached", n < 20, 1);
        rst_n = 1'b0;
        #2;
        check64("rst_mid_mem_read", mem_read, 0);
        check64("rst_mid_mem_write", mem_write, 0);
        @(posedge clk); #1;
        check64("rst_mid_next_mem_write", mem_write, 0);
        rst_n = 1'b1;
        idle(4);
        check64("rst_mid_ld_ready", ld_ready, 1);
        check64("rst_mid_st_ready", st_ready, 1);
        check64("rst_mid_mem_unchanged", mem[64], 8'h40);

        // Still functional after reset
        expect_st(64'h50, 64'h0123456789ABCDEF, 1'b0);
        do_store(64'h50, 64'h0123456789ABCDEF, 2'd3, 1'b0);
        do_load(64'h50, 2'd3, 1'b0, 1'b0, 64'h0123456789ABCDEF);
        idle(6);

        checkint("queue_full_seen", int'(saw_full), 1);
        checkint("pending_writes", exp_wr.size(), 0);
        checkint("pending_reads", exp_rd.size(), 0);
        checkint("pending_loads", exp_ld.size(), 0);
        checkint("pending_errs", exp_err.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
